// File: rtl/accelerator_dnc_pkg.sv
// Shared DNC accelerator types: scaler FSM states, 1-bit constants
// and fixed-point helper widths.
package accelerator_dnc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCALE
  } state_t;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  // Full-precision product width of two data words.
  function automatic int prod_width(input int data_size);
    return 2 * data_size;
  endfunction

endpackage

// File: rtl/accelerator_read_strength_multiplier.sv
// Registered signed fixed-point multiply: (beta*score)>>>FRACTION_SIZE.
// Ports: clk, rst_n (sync), en, beta, score -> result, valid (1-cycle latency).
// Macro ACCELERATOR_READ_STRENGTH_SCALER_SATURATION_EN: clamp instead of wrap.
module accelerator_read_strength_multiplier
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] beta,
  input  logic [DATA_SIZE-1:0] score,
  output logic [DATA_SIZE-1:0] result,
  output logic                 valid
);

  localparam int PW = prod_width(DATA_SIZE);

`ifdef ACCELERATOR_READ_STRENGTH_SCALER_SATURATION_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic [PW-DATA_SIZE:0] top;
  logic                  ovf;
  logic [DATA_SIZE-1:0]  sat;
  logic [DATA_SIZE-1:0]  next;

  assign prod    = PW'($signed(beta)) * PW'($signed(score));
  assign shifted = prod >>> FRACTION_SIZE;

  // Result fits only if every bit above the sign position matches it.
  assign top = shifted[PW-1:DATA_SIZE-1];
  assign ovf = !((&top) || !(|top));
  assign sat = shifted[PW-1] ? {ONE, {(DATA_SIZE-1){ZERO}}}
                             : {ZERO, {(DATA_SIZE-1){ONE}}};
  assign next = (SAT_EN && ovf) ? sat : shifted[DATA_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      valid  <= ZERO;
    end else begin
      valid <= en;
      if (en) result <= next;
    end
  end

endmodule

// File: rtl/accelerator_read_strength_scaler.sv
// Scales each memory score by the read strength beta of its read head.
// Ports: CLK, RST (sync, active-low), START/READY, BETA_IN(+_ENABLE),
// SCORE_IN(+_ENABLE) -> SCORE_OUT(+_ENABLE), SIZE_R_IN, SIZE_N_IN.
// Macro ACCELERATOR_READ_STRENGTH_SCALER_SATURATION_EN selects clamping.
module accelerator_read_strength_scaler
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int R_MAX         = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    BETA_IN_ENABLE,
  input  logic                    SCORE_IN_ENABLE,
  output logic                    SCORE_OUT_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0]    BETA_IN,
  input  logic [DATA_SIZE-1:0]    SCORE_IN,
  output logic [DATA_SIZE-1:0]    SCORE_OUT
);

  localparam int AW = (R_MAX > 1) ? $clog2(R_MAX) : 1;
  localparam logic [CONTROL_SIZE-1:0] RMAX_C = CONTROL_SIZE'(R_MAX);
  localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE);

  state_t                  state;
  logic [CONTROL_SIZE-1:0] size_r;
  logic [CONTROL_SIZE-1:0] size_n;
  logic [CONTROL_SIZE-1:0] idx_i;
  logic [CONTROL_SIZE-1:0] idx_j;
  logic [DATA_SIZE-1:0]    buffer [R_MAX];
  logic [CONTROL_SIZE-1:0] r_sel;
  logic [AW-1:0]           buf_sel;
  logic                    last_i;
  logic                    last_j;
  logic                    accept;

  assign r_sel   = (SIZE_R_IN > RMAX_C) ? RMAX_C : SIZE_R_IN;
  assign buf_sel = idx_i[AW-1:0];
  assign last_i  = (idx_i == size_r - C_ONE);
  assign last_j  = (idx_j == size_n - C_ONE);
  assign accept  = (state == ST_SCALE) && SCORE_IN_ENABLE;

  accelerator_read_strength_multiplier #(
    .DATA_SIZE    (DATA_SIZE),
    .FRACTION_SIZE(FRACTION_SIZE)
  ) u_mul (
    .clk   (CLK),
    .rst_n (RST),
    .en    (accept),
    .beta  (buffer[buf_sel]),
    .score (SCORE_IN),
    .result(SCORE_OUT),
    .valid (SCORE_OUT_ENABLE)
  );

  // READY is registered alongside the multiplier output so the final
  // result and READY appear on the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= ST_IDLE;
      READY  <= ZERO;
      size_r <= '0;
      size_n <= '0;
      idx_i  <= '0;
      idx_j  <= '0;
      for (int k = 0; k < R_MAX; k++) buffer[k] <= '0;
    end else begin
      READY <= ZERO;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            size_r <= r_sel;
            size_n <= SIZE_N_IN;
            idx_i  <= '0;
            idx_j  <= '0;
            if (r_sel == '0 || SIZE_N_IN == '0) READY <= ONE;
            else state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (BETA_IN_ENABLE) begin
            buffer[buf_sel] <= BETA_IN;
            if (last_i) begin
              idx_i <= '0;
              state <= ST_SCALE;
            end else begin
              idx_i <= idx_i + C_ONE;
            end
          end
        end
        ST_SCALE: begin
          if (SCORE_IN_ENABLE) begin
            if (last_j) begin
              idx_j <= '0;
              if (last_i) begin
                state <= ST_IDLE;
                READY <= ONE;
              end else begin
                idx_i <= idx_i + C_ONE;
              end
            end else begin
              idx_j <= idx_j + C_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_read_strength_scaler.sv
// Self-checking bench for accelerator_read_strength_scaler
// (DATA_SIZE=16, FRACTION_SIZE=8, R_MAX=4, CONTROL_SIZE=16).
module tb_accelerator_read_strength_scaler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        READY;
  logic        BETA_IN_ENABLE;
  logic        SCORE_IN_ENABLE;
  logic        SCORE_OUT_ENABLE;
  logic [15:0] SIZE_R_IN;
  logic [15:0] SIZE_N_IN;
  logic [15:0] BETA_IN;
  logic [15:0] SCORE_IN;
  logic [15:0] SCORE_OUT;

  accelerator_read_strength_scaler #(
    .DATA_SIZE    (16),
    .CONTROL_SIZE (16),
    .FRACTION_SIZE(8),
    .R_MAX        (4)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .START           (START),
    .READY           (READY),
    .BETA_IN_ENABLE  (BETA_IN_ENABLE),
    .SCORE_IN_ENABLE (SCORE_IN_ENABLE),
    .SCORE_OUT_ENABLE(SCORE_OUT_ENABLE),
    .SIZE_R_IN       (SIZE_R_IN),
    .SIZE_N_IN       (SIZE_N_IN),
    .BETA_IN         (BETA_IN),
    .SCORE_IN        (SCORE_IN),
    .SCORE_OUT       (SCORE_OUT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic        exp_en;
  logic        exp_ready;
  logic [15:0] exp_out;

  logic [15:0] betas [8];
  logic [15:0] scores [32];

  // Reference: floor((beta*score)/2^8) on plain integers, then clamp or wrap.
  function automatic logic [15:0] model(input logic [15:0] b,
                                        input logic [15:0] s);
    longint p;
    longint q;
    p = longint'($signed(b)) * longint'($signed(s));
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
`ifdef ACCELERATOR_READ_STRENGTH_SCALER_SATURATION_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    #1;
    chk({tag, ".en"}, {31'd0, SCORE_OUT_ENABLE}, {31'd0, exp_en});
    chk({tag, ".ready"}, {31'd0, READY}, {31'd0, exp_ready});
    chk({tag, ".out"}, {16'd0, SCORE_OUT}, {16'd0, exp_out});
  endtask

  task automatic run_pass(input int r_in, input int n_in, input int gaps,
                          input bit extra, input int abort_at);
    int r_eff;
    int total;
    r_eff = (r_in > 4) ? 4 : r_in;
    total = r_eff * n_in;
    START     = 1'b1;
    SIZE_R_IN = 16'(r_in);
    SIZE_N_IN = 16'(n_in);
    exp_en    = 1'b0;
    exp_ready = (total == 0);
    step("start");
    START = 1'b0;
    if (total == 0) begin
      exp_ready = 1'b0;
      step("zero_after");
      return;
    end
    exp_ready = 1'b0;
    for (int k = 0; k < r_eff; k++) begin
      if (extra && k == 0) begin
        START     = 1'b1;
        SIZE_R_IN = 16'd1;
        SIZE_N_IN = 16'd1;
      end
      BETA_IN_ENABLE = 1'b1;
      BETA_IN        = betas[k];
      step("load");
      START = 1'b0;
    end
    BETA_IN_ENABLE = 1'b0;
    for (int idx = 0; idx < total; idx++) begin
      int g;
      g = (gaps > 0) ? int'($urandom_range(0, gaps)) : 0;
      for (int c = 0; c < g; c++) begin
        SCORE_IN_ENABLE = 1'b0;
        SCORE_IN        = 16'($urandom);
        exp_en          = 1'b0;
        exp_ready       = 1'b0;
        step("gap");
      end
      if (extra) begin
        BETA_IN_ENABLE = 1'b1;
        BETA_IN        = 16'($urandom);
        START          = 1'b1;
      end
      SCORE_IN_ENABLE = 1'b1;
      SCORE_IN        = scores[idx];
      if (idx == abort_at) begin
        RST       = 1'b0;
        exp_en    = 1'b0;
        exp_ready = 1'b0;
        exp_out   = 16'h0000;
        step("abort");
        RST             = 1'b1;
        SCORE_IN_ENABLE = 1'b0;
        BETA_IN_ENABLE  = 1'b0;
        START           = 1'b0;
        step("post_abort");
        return;
      end
      exp_out   = model(betas[idx / n_in], scores[idx]);
      exp_en    = 1'b1;
      exp_ready = (idx == total - 1);
      step("scale");
    end
    SCORE_IN_ENABLE = 1'b0;
    BETA_IN_ENABLE  = 1'b0;
    START           = 1'b0;
    exp_en          = 1'b0;
    exp_ready       = 1'b0;
    step("done");
  endtask

  initial begin
    RST             = 1'b0;
    START           = 1'b0;
    BETA_IN_ENABLE  = 1'b0;
    SCORE_IN_ENABLE = 1'b0;
    SIZE_R_IN       = '0;
    SIZE_N_IN       = '0;
    BETA_IN         = '0;
    SCORE_IN        = '0;
    exp_en          = 1'b0;
    exp_ready       = 1'b0;
    exp_out         = 16'h0000;
    for (int k = 0; k < 8; k++) betas[k] = '0;
    for (int k = 0; k < 32; k++) scores[k] = '0;

    step("reset0");
    step("reset1");
    RST = 1'b1;
    step("idle");

    // Single head, single row.
    betas[0] = 16'h0200;
    scores[0] = 16'h0180;
    run_pass(1, 1, 0, 1'b0, -1);
    chk("r1n1.value", {16'd0, SCORE_OUT}, 32'h0300);

    // Two heads, three rows, back-to-back scores.
    betas[0] = 16'h0100;
    betas[1] = 16'h0200;
    for (int k = 0; k < 6; k++) scores[k] = 16'h0100;
    run_pass(2, 3, 0, 1'b0, -1);
    chk("r2n3.last", {16'd0, SCORE_OUT}, 32'h0200);

    // Negative score.
    betas[0] = 16'h0200;
    scores[0] = 16'hFF80;
    run_pass(1, 1, 0, 1'b0, -1);
    chk("sign.value", {16'd0, SCORE_OUT}, 32'hFF00);

    // Overflow.
    betas[0] = 16'h7F00;
    scores[0] = 16'h0200;
    run_pass(1, 1, 0, 1'b0, -1);
`ifdef ACCELERATOR_READ_STRENGTH_SCALER_SATURATION_EN
    chk("ovf.value", {16'd0, SCORE_OUT}, 32'h7FFF);
`else
    chk("ovf.value", {16'd0, SCORE_OUT}, 32'hFE00);
`endif

    // Empty passes.
    run_pass(2, 0, 0, 1'b0, -1);
    run_pass(0, 3, 0, 1'b0, -1);

    // Score strobe in IDLE is ignored.
    SCORE_IN_ENABLE = 1'b1;
    SCORE_IN        = 16'h1234;
    step("idle_score");
    SCORE_IN_ENABLE = 1'b0;

    // R clamps to 4; busy-time START/BETA strobes ignored.
    for (int k = 0; k < 8; k++) betas[k] = 16'(16'h0040 * (k + 1));
    for (int k = 0; k < 8; k++) scores[k] = 16'(16'h0100 + k);
    run_pass(9, 2, 0, 1'b1, -1);

    // Reset in the middle of SCALE, then a clean pass.
    betas[0] = 16'h0300;
    betas[1] = 16'hFE00;
    for (int k = 0; k < 6; k++) scores[k] = 16'(16'h0080 * (k + 1));
    run_pass(2, 3, 0, 1'b0, 2);
    run_pass(2, 3, 1, 1'b0, -1);

    // Randomized passes.
    for (int t = 0; t < 25; t++) begin
      int r;
      int n;
      r = int'($urandom_range(1, 6));
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < 8; k++)
        betas[k] = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                               : 16'($urandom_range(0, 1023));
      for (int k = 0; k < 32; k++)
        scores[k] = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                : 16'($urandom_range(0, 511));
      run_pass(r, n, 2, ($urandom_range(0, 1) == 1), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accelerator_read_strength_scaler.md
ACCELERATOR_READ_STRENGTH_SCALER -- requirements
Module: accelerator_read_strength_scaler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, signed two's-complement fixed-point word width.
REQ-002 SHALL have parameter CONTROL_SIZE, default 64, width of size/index counters.
REQ-003 SHALL have parameter FRACTION_SIZE, default 32, fractional bits of every data word.
REQ-004 SHALL have parameter R_MAX, default 8, depth of the beta buffer (max read heads).
REQ-005 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port START  input  1  begin one scaling pass; sampled only in IDLE.
REQ-008 SHALL have port READY  output  1  one-cycle pulse when a pass completes.
REQ-009 SHALL have port BETA_IN_ENABLE  input  1  BETA_IN valid (one beta(t;i) per pulse, i ascending).
REQ-010 SHALL have ports SCORE_IN_ENABLE  input  1 and SCORE_OUT_ENABLE  output  1  score in/out valid strobes.
REQ-011 SHALL have ports SIZE_R_IN, SIZE_N_IN  input  CONTROL_SIZE  head count R, memory rows N.
REQ-012 SHALL have ports BETA_IN, SCORE_IN  input  DATA_SIZE; SCORE_OUT  output  DATA_SIZE.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> SCALE -> IDLE; state outside IDLE means busy.
REQ-014 SHALL, on START in IDLE, latch R=min(SIZE_R_IN,R_MAX) and N; clear indices i, j; enter LOAD.
REQ-015 SHALL, if latched R or N is 0, pulse READY the next cycle and return to IDLE with no outputs.
REQ-016 SHALL, in LOAD, write BETA_IN to buffer[i] per BETA_IN_ENABLE; after entry R-1 reset i to 0 and enter SCALE.
REQ-017 SHALL, in SCALE, per SCORE_IN_ENABLE, compute (buffer[i]*SCORE_IN) arithmetically shifted right FRACTION_SIZE (floor rounding) and present it on SCORE_OUT with SCORE_OUT_ENABLE exactly one cycle later.
REQ-018 SHALL advance j per accepted score; at j=N-1 wrap j to 0 and increment i.
REQ-019 SHALL, on the cycle the (R-1,N-1) result is output, also pulse READY and return to IDLE.
REQ-020 SHALL ignore START while busy, BETA_IN_ENABLE outside LOAD, SCORE_IN_ENABLE outside SCALE.
REQ-021 SHALL hold SCORE_OUT at last value when SCORE_OUT_ENABLE is low; strobes are never high two cycles unless inputs are.
REQ-022 SHALL accept back-to-back SCORE_IN_ENABLE every cycle (throughput 1/cycle).

Reset
REQ-023 SHALL, while RST=0 at a clock edge, force IDLE, READY=0, SCORE_OUT_ENABLE=0, SCORE_OUT=0, i=j=0, R=N=0, buffer all zero.
REQ-024 SHALL abort any pass on reset mid-operation with no READY pulse; first START after RST returns high starts cleanly.

Configuration
REQ-025 SHALL use macro ACCELERATOR_READ_STRENGTH_SCALER_SATURATION_EN: defined -> results beyond DATA_SIZE range clamp to max positive/min negative; undefined -> results are the low DATA_SIZE bits (wrap).

Structure
REQ-026 SHALL take FSM state enum, ZERO/ONE constants and fixed-point helper widths from shared package accelerator_dnc_pkg.
REQ-027 SHALL instantiate one sub-module accelerator_read_strength_multiplier (registered signed multiply, shift, optional saturate).

Verification (DATA_SIZE=16, FRACTION_SIZE=8, R_MAX=4)
REQ-028 SHALL test R=1,N=1: beta 0x0200, score 0x0180 -> SCORE_OUT 0x0300 one cycle later, READY same cycle.
REQ-029 SHALL test R=2,N=3: betas 0x0100,0x0200, six scores 0x0100 back-to-back -> outputs 0x0100 x3 then 0x0200 x3, READY with sixth.
REQ-030 SHALL test sign: beta 0x0200, score 0xFF80 -> 0xFF00.
REQ-031 SHALL test overflow: beta 0x7F00, score 0x0200 -> 0x7FFF with macro, 0xFE00 without.
REQ-032 SHALL test SIZE_N_IN=0 -> READY pulse one cycle after START, no SCORE_OUT_ENABLE; SIZE_R_IN=9 -> only 4 betas loaded.
REQ-033 SHALL test RST low during SCALE -> all outputs zero next edge, no READY; START while busy ignored.
